// File: rtl/approx_mult_err_monitor.sv
// Sweeps all operand pairs into an external multiplier and accumulates error statistics.
// Optional overshoot counter enabled by defining ERR_MON_OVERSHOOT_EN.
module approx_mult_err_monitor #(
  parameter int unsigned W             = 4,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  input  logic [2*W-1:0]   approx_y,
  output logic             busy,
  output logic             done,
  output logic [2*W:0]     match_count,
  output logic [2*W:0]     err_count,
  output logic [4*W-1:0]   sum_ed,
  output logic [2*W-1:0]   max_ed,
  output logic [2*W:0]     over_count
);

  localparam int unsigned CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]  SettleLast = CW'(SETTLE_CYCLES);
  localparam logic [W-1:0]   OpMax      = '1;
  localparam logic [2*W:0]   CntOne     = (2*W+1)'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    settle_q, settle_d;
  logic [W-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2*W:0]     match_q, match_d, err_q, err_d;
  logic [4*W-1:0]   sum_q, sum_d;
  logic [2*W-1:0]   max_q, max_d;
  logic [2*W-1:0]   exact, ed;
  logic             clear, sample;

  assign exact  = {{W{1'b0}}, op_a_q} * {{W{1'b0}}, op_b_q};
  assign ed     = (approx_y >= exact) ? (approx_y - exact) : (exact - approx_y);
  assign clear  = (state_q != StRun) && start;
  assign sample = (state_q == StRun) && (settle_q == SettleLast);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    match_d  = match_q;
    err_d    = err_q;
    sum_d    = sum_q;
    max_d    = max_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StRun;
          settle_d = '0;
          op_a_d   = '0;
          op_b_d   = '0;
          match_d  = '0;
          err_d    = '0;
          sum_d    = '0;
          max_d    = '0;
        end
      end
      StRun: begin
        if (sample) begin
          settle_d = '0;
          if (ed == '0) match_d = match_q + CntOne;
          else          err_d   = err_q + CntOne;
          sum_d = sum_q + {{(2*W){1'b0}}, ed};
          if (ed > max_q) max_d = ed;
          // Final pair keeps its operands so the frozen state shows where the sweep ended.
          if ((op_a_q == OpMax) && (op_b_q == OpMax)) begin
            state_d = StDone;
          end else begin
            op_b_d = op_b_q + 1'b1;
            if (op_b_q == OpMax) op_a_d = op_a_q + 1'b1;
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      settle_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      match_q  <= '0;
      err_q    <= '0;
      sum_q    <= '0;
      max_q    <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      match_q  <= match_d;
      err_q    <= err_d;
      sum_q    <= sum_d;
      max_q    <= max_d;
    end
  end

`ifdef ERR_MON_OVERSHOOT_EN
  logic [2*W:0] over_q, over_d;

  always_comb begin
    over_d = over_q;
    if (clear)                             over_d = '0;
    else if (sample && (approx_y > exact)) over_d = over_q + CntOne;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) over_q <= '0;
    else        over_q <= over_d;
  end

  assign over_count = over_q;
`else
  assign over_count = '0;
`endif

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign match_count = match_q;
  assign err_count   = err_q;
  assign sum_ed      = sum_q;
  assign max_ed      = max_q;

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Scoreboard bench: sweeps push expected statistics, a negedge monitor checks them on done.
module tb_approx_mult_err_monitor;
  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   op_a, op_b;
  logic [2*W-1:0] approx_y;
  logic           busy, done;
  logic [2*W:0]   match_count, err_count, over_count;
  logic [4*W-1:0] sum_ed;
  logic [2*W-1:0] max_ed;

  logic           start3 = 1'b0;
  logic [W-1:0]   op_a3, op_b3;
  logic [2*W-1:0] approx_y3;
  logic           busy3, done3;
  logic [2*W:0]   match3, err3, over3;
  logic [4*W-1:0] sum3;
  logic [2*W-1:0] max3;

  int unsigned mode = 0;
  int unsigned cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int unsigned match, err, sum, maxe, over, lat, start_cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic done_prev = 1'b0;

`ifdef ERR_MON_OVERSHOOT_EN
  localparam int unsigned OverPlus1 = 256;
`else
  localparam int unsigned OverPlus1 = 0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier models under test: 0 exact, 1 LSB forced 0, 2 zero at a=b=15, 3 product+1.
  always_comb begin
    logic [2*W-1:0] ex;
    ex = {4'b0, op_a} * {4'b0, op_b};
    case (mode)
      1:       approx_y = ex & 8'hFE;
      2:       approx_y = (op_a == 4'd15 && op_b == 4'd15) ? 8'd0 : ex;
      3:       approx_y = ex + 8'd1;
      default: approx_y = ex;
    endcase
  end
  assign approx_y3 = {4'b0, op_a3} * {4'b0, op_b3};

  approx_mult_err_monitor #(.W(W), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .approx_y(approx_y), .busy(busy), .done(done), .match_count(match_count),
    .err_count(err_count), .sum_ed(sum_ed), .max_ed(max_ed), .over_count(over_count)
  );

  approx_mult_err_monitor #(.W(W), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .op_a(op_a3), .op_b(op_b3),
    .approx_y(approx_y3), .busy(busy3), .done(done3), .match_count(match3),
    .err_count(err3), .sum_ed(sum3), .max_ed(max3), .over_count(over3)
  );

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got done=1, expected no pending sweep");
      end else begin
        e = sb.pop_front();
        check("latency", cyc - e.start_cyc, e.lat);
        check("match_count", match_count, e.match);
        check("err_count", err_count, e.err);
        check("sum_ed", sum_ed, e.sum);
        check("max_ed", max_ed, e.maxe);
        check("over_count", over_count, e.over);
        check("busy_at_done", busy, 0);
        check("op_a_final", op_a, 15);
        check("op_b_final", op_b, 15);
      end
    end
    done_prev <= done;
  end

  task automatic sweep(input int unsigned m, input int unsigned em, input int unsigned ee,
                       input int unsigned es, input int unsigned ex, input int unsigned eo,
                       input bit pulse);
    exp_t x;
    @(negedge clk);
    mode = m;
    x.match = em; x.err = ee; x.sum = es; x.maxe = ex; x.over = eo; x.lat = 512;
    x.start_cyc = cyc + 1;
    sb.push_back(x);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (pulse) begin
      repeat (50) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 2000 && !done; i++) @(negedge clk);
    if (!done) begin
      n_total++;
      $display("FAIL sweep_timeout: got done=0, expected done=1");
    end
    @(negedge clk);
  endtask

  initial begin
    int unsigned t3;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_op_a", op_a, 0);
    check("rst_match", match_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    sweep(0, 256, 0, 0, 0, 0, 1'b0);
    sweep(1, 192, 64, 64, 1, 0, 1'b0);
    sweep(2, 255, 1, 225, 225, 0, 1'b0);
    sweep(3, 0, 256, 256, 1, OverPlus1, 1'b0);

    // Reset mid-sweep
    @(negedge clk);
    mode = 1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    check("busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_op_a", op_a, 0);
    check("midrst_op_b", op_b, 0);
    check("midrst_match", match_count, 0);
    check("midrst_err", err_count, 0);
    check("midrst_sum", sum_ed, 0);
    check("midrst_max", max_ed, 0);
    check("midrst_over", over_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    sweep(1, 192, 64, 64, 1, 0, 1'b0);
    sweep(2, 255, 1, 225, 225, 0, 1'b1);

    @(negedge clk);
    t3 = cyc + 1;
    start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    for (int i = 0; i < 3000 && !done3; i++) @(negedge clk);
    check("s3_latency", cyc - t3, 1024);
    check("s3_match", match3, 256);
    check("s3_err", err3, 0);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
